// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared types and constants for the reaction-time game sequencer
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    GO,
    DONE,
    FOUL
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam int          RT_W      = 14;
  localparam logic [13:0] BEST_INIT = 14'h3FFF;

  // Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/reaction_ctrl_ms_tick.sv
// rtl/reaction_ctrl_ms_tick.sv - millisecond prescaler with synchronous clear
module ms_tick #(
  parameter int CLK_HZ = 12_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int DIV = CLK_HZ / 1000;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TERM = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || r_cnt == TERM) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == TERM);

endmodule

// File: rtl/reaction_ctrl.sv
// rtl/reaction_ctrl.sv - reaction-time game sequencer (delay, GO, timing, foul)
// Optional best-result register enabled by macro REACTION_BEST_EN.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int MIN_DLY_MS = 1000,
  parameter int RND_BITS   = 11,
  parameter int MAX_MS     = 9999
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_start,
  input  logic            btn_resp,
  output logic            led_go,
  output logic            led_foul,
  output logic            busy,
  output logic [RT_W-1:0] rt_ms,
  output logic            rt_valid,
  output logic [RT_W-1:0] best_ms
);

  localparam logic [15:0]     MIN_DLY = 16'(MIN_DLY_MS);
  localparam logic [RT_W-1:0] MAX_CNT = RT_W'(MAX_MS);

  state_t          r_state;
  state_t          w_next;
  logic            r_start_q;
  logic            r_resp_q;
  logic [15:0]     r_lfsr;
  logic [15:0]     r_dly;
  logic [RT_W-1:0] r_rt_cnt;
  logic [RT_W-1:0] r_rt_ms;
  logic            r_rt_valid;
  logic            w_start_rise;
  logic            w_resp_rise;
  logic            w_tick;
  logic            w_clr;

  assign w_start_rise = btn_start & ~r_start_q;
  assign w_resp_rise  = btn_resp & ~r_resp_q;

  ms_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_ms_tick (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .o_tick(w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A response in the expiry cycle is checked first so it counts as a foul.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    case (r_state)
      IDLE: if (w_start_rise) w_next = WAIT;
      WAIT: begin
        if (w_resp_rise) w_next = FOUL;
        else if (w_tick && r_dly == 16'd1) w_next = GO;
      end
      GO: begin
        if (w_resp_rise || r_rt_cnt == MAX_CNT) w_next = DONE;
      end
      DONE: if (w_start_rise) w_next = WAIT;
      FOUL: if (w_start_rise) w_next = WAIT;
      default: w_next = IDLE;
    endcase
    if (r_state != WAIT && w_next == WAIT) w_clr = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_q  <= 1'b1;
      r_resp_q   <= 1'b1;
      r_lfsr     <= LFSR_SEED;
      r_dly      <= '0;
      r_rt_cnt   <= '0;
      r_rt_ms    <= '0;
      r_rt_valid <= 1'b0;
    end else begin
      r_start_q  <= btn_start;
      r_resp_q   <= btn_resp;
      r_lfsr     <= lfsr_next(r_lfsr);
      r_rt_valid <= 1'b0;

      if (w_clr) begin
        r_dly <= MIN_DLY + 16'(r_lfsr[RND_BITS-1:0]);
      end else if (r_state == WAIT && w_tick) begin
        r_dly <= r_dly - 16'd1;
      end

      if (r_state == WAIT && w_next == GO) begin
        r_rt_cnt <= '0;
      end else if (r_state == GO && w_tick && r_rt_cnt != MAX_CNT) begin
        r_rt_cnt <= r_rt_cnt + 1'b1;
      end

      // Count before any same-cycle increment; equals MAX_CNT on timeout.
      if (r_state == GO && w_next == DONE) begin
        r_rt_ms    <= r_rt_cnt;
        r_rt_valid <= 1'b1;
      end
    end
  end

`ifdef REACTION_BEST_EN
  logic [RT_W-1:0] r_best;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_best <= BEST_INIT;
    end else if (r_rt_valid && r_rt_ms != MAX_CNT && r_rt_ms < r_best) begin
      r_best <= r_rt_ms;
    end
  end

  assign best_ms = r_best;
`else
  assign best_ms = BEST_INIT;
`endif

  assign led_go   = (r_state == GO);
  assign led_foul = (r_state == FOUL);
  assign busy     = (r_state == WAIT) || (r_state == GO);
  assign rt_ms    = r_rt_ms;
  assign rt_valid = r_rt_valid;

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb/tb_reaction_ctrl.sv - directed self-checking bench for reaction_ctrl
module tb_reaction_ctrl;

  localparam int CLK_HZ  = 10_000;
  localparam int MIN_DLY = 5;
  localparam int MAX_MS  = 60;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_start;
  logic        btn_resp;
  logic        led_go;
  logic        led_foul;
  logic        busy;
  logic [13:0] rt_ms;
  logic        rt_valid;
  logic [13:0] best_ms;

  int total = 0;
  int bad   = 0;
  logic [15:0] m_lfsr;

  reaction_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .MIN_DLY_MS(MIN_DLY),
    .RND_BITS  (2),
    .MAX_MS    (MAX_MS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_start(btn_start),
    .btn_resp (btn_resp),
    .led_go   (led_go),
    .led_foul (led_foul),
    .busy     (busy),
    .rt_ms    (rt_ms),
    .rt_valid (rt_valid),
    .best_ms  (best_ms)
  );

  always #5 clk = ~clk;

  // Reference sequence: x^16+x^14+x^13+x^11 shifting left from 16'hACE1
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [13:0] exp_best(input logic [13:0] v);
`ifdef REACTION_BEST_EN
    return v;
`else
    return 14'h3FFF;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn_start = 1'b0;
    btn_resp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic begin_round(output int d);
    d = MIN_DLY + int'(m_lfsr[1:0]);
    btn_start = 1'b1;
    @(negedge clk);
    btn_start = 1'b0;
    chk("start_busy", busy, 1);
  endtask

  task automatic wait_go(output int n);
    n = 0;
    while (led_go !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_round(input int react);
    int d;
    int n;
    begin_round(d);
    wait_go(n);
    chk("go_latency", n, 10 * d);
    repeat (10 * react + 4) @(negedge clk);
    btn_resp = 1'b1;
    @(negedge clk);
    chk("done_valid", rt_valid, 1);
    chk("done_rt_ms", rt_ms, react);
    chk("done_go_off", led_go, 0);
    btn_resp = 1'b0;
    @(negedge clk);
    chk("valid_pulse", rt_valid, 0);
    @(negedge clk);
  endtask

  initial begin
    int d;
    int n;
    rst = 1'b1;
    btn_start = 1'b1;
    btn_resp = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_go", led_go, 0);
    chk("rst_foul", led_foul, 0);
    chk("rst_rt_ms", rt_ms, 0);
    chk("rst_valid", rt_valid, 0);
    chk("rst_best", best_ms, 14'h3FFF);
    btn_start = 1'b0;
    @(negedge clk);
    chk("release_idle", busy, 0);

    run_round(37);
    chk("best_37", best_ms, exp_best(14'd37));

    begin_round(d);
    repeat (20) @(negedge clk);
    btn_resp = 1'b1;
    @(negedge clk);
    btn_resp = 1'b0;
    chk("foul_led", led_foul, 1);
    chk("foul_busy", busy, 0);
    chk("foul_rt_ms", rt_ms, 37);
    chk("foul_valid", rt_valid, 0);
    @(negedge clk);
    chk("foul_hold", led_foul, 1);

    begin_round(d);
    chk("restart_foul_off", led_foul, 0);
    repeat (10 * d - 1) @(negedge clk);
    chk("expiry_pre_go", led_go, 0);
    btn_resp = 1'b1;
    @(negedge clk);
    btn_resp = 1'b0;
    chk("expiry_foul", led_foul, 1);
    chk("expiry_no_go", led_go, 0);
    repeat (30) @(negedge clk);
    chk("expiry_still_no_go", led_go, 0);

    do_reset();
    begin_round(d);
    wait_go(n);
    chk("tmo_go_latency", n, 10 * d);
    n = 0;
    while (rt_valid !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_latency", n, 10 * MAX_MS + 1);
    chk("tmo_rt_ms", rt_ms, MAX_MS);
    chk("tmo_go_off", led_go, 0);
    repeat (2) @(negedge clk);
    chk("tmo_best", best_ms, 14'h3FFF);

    do_reset();
    run_round(40);
    chk("best_40", best_ms, exp_best(14'd40));
    run_round(25);
    chk("best_25", best_ms, exp_best(14'd25));
    run_round(30);
    chk("best_30", best_ms, exp_best(14'd25));
    chk("last_rt_30", rt_ms, 30);

    begin_round(d);
    wait_go(n);
    chk("mid_go_latency", n, 10 * d);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_go", led_go, 0);
    chk("arst_rt_ms", rt_ms, 0);
    chk("arst_best", best_ms, 14'h3FFF);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
